// File: rtl/sccb_target.sv
// SCCB target: decodes 3-phase writes and 2-phase reads into register strobes.
// Optional I2C-style ACK on the 9th bit when SCCB_TARGET_ACK_EN is defined.
module sccb_target #(
    parameter logic [7:0] DEVICE_ID   = 8'h60,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       reg_wr_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_rd_req,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

`ifdef SCCB_TARGET_ACK_EN
    localparam logic ACK = 1'b1;
`else
    localparam logic ACK = 1'b0;
`endif

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [3:0] {
        IDLE, ID, ID_X, SUB, SUB_X, DATA, DATA_X, RD_DATA, RD_NA, IGNORE
    } state_t;

    logic [SS-1:0] scl_sync, sda_sync;
    logic          scl_d, sda_d, scl_s, sda_s;
    logic          scl_rise, scl_fall, start, stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SS-2:0], scl_in};
            sda_sync <= {sda_sync[SS-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SS-1];
    assign sda_s    = sda_sync[SS-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [6:0] shift, shift_n;
    logic [7:0] tx_shift, tx_n;
    logic       rw, rw_n, nine_hi, nine_hi_n;
    logic       oe_n, wr_en_n, rd_req_n, busy_n;
    logic [7:0] addr_n, wdata_n, byte_in;

    assign byte_in = {shift, sda_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            tx_shift    <= '0;
            rw          <= 1'b0;
            nine_hi     <= 1'b0;
            sda_oe      <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_rd_req  <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            tx_shift    <= tx_n;
            rw          <= rw_n;
            nine_hi     <= nine_hi_n;
            sda_oe      <= oe_n;
            reg_wr_en   <= wr_en_n;
            reg_rd_req  <= rd_req_n;
            reg_addr    <= addr_n;
            reg_wr_data <= wdata_n;
            busy        <= busy_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        tx_n      = tx_shift;
        rw_n      = rw;
        nine_hi_n = nine_hi;
        oe_n      = sda_oe;
        wr_en_n   = 1'b0;
        rd_req_n  = 1'b0;
        addr_n    = reg_addr;
        wdata_n   = reg_wr_data;
        busy_n    = busy;
        // read data arrives the cycle after the request
        if (reg_rd_req)
            tx_n = reg_rd_data;
        unique case (1'b1)
            stop: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                oe_n    = 1'b0;
            end
            start: begin
                state_n   = ID;
                bit_cnt_n = '0;
                busy_n    = 1'b1;
                oe_n      = 1'b0;
                nine_hi_n = 1'b0;
            end
            default: begin
                case (state)
                    ID, SUB, DATA: begin
                        if (scl_rise) begin
                            shift_n   = byte_in[6:0];
                            bit_cnt_n = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                nine_hi_n = 1'b0;
                                case (state)
                                    ID: begin
                                        if (byte_in[7:1] != DEVICE_ID[7:1]) begin
                                            state_n = IGNORE;
                                        end else begin
                                            rw_n     = byte_in[0];
                                            rd_req_n = byte_in[0];
                                            state_n  = ID_X;
                                        end
                                    end
                                    SUB: begin
                                        addr_n  = byte_in;
                                        state_n = SUB_X;
                                    end
                                    default: begin
                                        wdata_n = byte_in;
                                        wr_en_n = 1'b1;
                                        state_n = DATA_X;
                                    end
                                endcase
                            end
                        end
                    end
                    ID_X, SUB_X, DATA_X: begin
                        if (scl_rise)
                            nine_hi_n = 1'b1;
                        // first fall opens the 9th bit, the one after its rise closes it
                        if (scl_fall) begin
                            if (!nine_hi) begin
                                oe_n = ACK;
                            end else begin
                                oe_n = 1'b0;
                                case (state)
                                    ID_X: begin
                                        if (rw) begin
                                            state_n = RD_DATA;
                                            oe_n    = ~tx_shift[7];
                                        end else begin
                                            state_n = SUB;
                                        end
                                    end
                                    SUB_X:   state_n = DATA;
                                    default: state_n = IGNORE;
                                endcase
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise)
                            bit_cnt_n = bit_cnt + 3'd1;
                        // entered on a fall, so a fall at bit_cnt 0 follows the 8th bit
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                oe_n    = 1'b0;
                                state_n = RD_NA;
                            end else begin
                                tx_n = {tx_shift[6:0], 1'b0};
                                oe_n = ~tx_shift[6];
                            end
                        end
                    end
                    RD_NA: begin
                        if (scl_rise)
                            state_n = IGNORE;
                    end
                    IGNORE: oe_n = 1'b0;
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB initiator, transaction-level
// reference model and an emulated register file answering read requests.
`timescale 1ns/1ps
module tb_sccb_target;

    localparam int Q = 80;
`ifdef SCCB_TARGET_ACK_EN
    localparam logic ACK = 1'b1;
`else
    localparam logic ACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe, reg_wr_en, reg_rd_req, busy;
    logic [7:0] reg_addr, reg_wr_data, reg_rd_data;

    always #5 clk = ~clk;

    assign sda_in = sda_m & ~sda_oe;

    sccb_target dut (
        .clk         (clk),
        .rst         (rst),
        .scl_in      (scl),
        .sda_in      (sda_in),
        .sda_oe      (sda_oe),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_req  (reg_rd_req),
        .reg_rd_data (reg_rd_data),
        .busy        (busy)
    );

    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    logic [7:0] m_addr;
    logic [7:0] wr_a[$];
    logic [7:0] wr_d[$];
    int         rd_cnt;
    logic [7:0] rd_a;
    logic       oe_any;

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_a.push_back(reg_addr);
            wr_d.push_back(reg_wr_data);
            mem[reg_addr] = reg_wr_data;
        end
        if (reg_rd_req) begin
            rd_cnt++;
            rd_a = reg_addr;
            reg_rd_data = mem[reg_addr];
        end
        if (sda_oe)
            oe_any = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; #Q;
        scl = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; #Q;
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--)
            put_bit(b[i]);
        sda_m = 1'b1; #Q;
        scl = 1'b1; #Q;
        ack = sda_oe; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic read_byte(output logic [7:0] b, output logic na_oe);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; #Q;
            scl = 1'b1; #Q;
            b = {b[6:0], sda_in}; #Q;
            scl = 1'b0; #Q;
        end
        sda_m = 1'b1; #Q;
        scl = 1'b1; #Q;
        na_oe = sda_oe; #Q;
        scl = 1'b0; #Q;
    endtask

    // A write-type transaction: ID, optional sub-address, data, extras, STOP.
    task automatic wr_txn(input logic [7:0] bq[$]);
        logic a;
        bit   match;
        int   nw;
        wr_a.delete(); wr_d.delete();
        rd_cnt = 0; oe_any = 1'b0;
        match = (bq[0][7:1] == 7'h30) && !bq[0][0];
        bus_start();
        chk("busy_start", 32'(busy), 32'd1);
        foreach (bq[i]) begin
            send_byte(bq[i], a);
            chk($sformatf("ack_byte%0d", i), 32'(a), 32'(ACK && match && i < 3));
        end
        bus_stop();
        #(4*Q);
        nw = 0;
        if (match && bq.size() >= 2)
            m_addr = bq[1];
        if (match && bq.size() >= 3) begin
            nw = 1;
            exp_mem[m_addr] = bq[2];
        end
        chk("busy_stop", 32'(busy), 32'd0);
        chk("wr_count", 32'(wr_a.size()), 32'(nw));
        if (nw == 1 && wr_a.size() == 1) begin
            chk("wr_addr", 32'(wr_a[0]), 32'(m_addr));
            chk("wr_data", 32'(wr_d[0]), 32'(bq[2]));
        end
        chk("reg_addr", 32'(reg_addr), 32'(m_addr));
        chk("wr_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("oe_any", 32'(oe_any), 32'(ACK && match));
    endtask

    task automatic rd_txn(input logic [7:0] id, input bit rs);
        logic       a, na_oe;
        logic [7:0] got;
        bit         match;
        match = (id[7:1] == 7'h30) && id[0];
        wr_a.delete(); wr_d.delete();
        rd_cnt = 0;
        if (rs) bus_rstart();
        else bus_start();
        send_byte(id, a);
        chk("rd_ack", 32'(a), 32'(ACK && match));
        if (match) begin
            read_byte(got, na_oe);
            chk("rd_data", 32'(got), 32'(exp_mem[m_addr]));
            chk("na_release", 32'(na_oe), 32'd0);
            chk("rd_addr", 32'(rd_a), 32'(m_addr));
        end
        bus_stop();
        #(4*Q);
        chk("rd_cnt", 32'(rd_cnt), 32'(match));
        chk("rd_wr_cnt", 32'(wr_a.size()), 32'd0);
        chk("rd_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] v, id;
        logic       a;
        int         kind;

        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            exp_mem[i] = v;
        end
        m_addr = 8'h00;
        rd_cnt = 0;
        oe_any = 1'b0;
        rd_a = 8'h00;
        reg_rd_data = 8'h00;

        #23;
        chk("reset_outs", {26'd0, sda_oe, reg_wr_en, reg_rd_req, busy, 2'b00},
            32'd0);
        chk("reset_regs", {16'd0, reg_addr, reg_wr_data}, 32'd0);
        #17 rst = 1'b0;
        #(4*Q);

        q = {8'h60, 8'h12, 8'h80};
        wr_txn(q);

        mem[8'hFF] = 8'hA5;
        exp_mem[8'hFF] = 8'hA5;
        q = {8'h60, 8'hFF};
        wr_txn(q);
        rd_txn(8'h61, 1'b0);

        q = {8'h42, 8'h12, 8'h55};
        wr_txn(q);

        v = 8'($urandom);
        mem[8'h0A] = v;
        exp_mem[8'h0A] = v;
        wr_a.delete(); wr_d.delete();
        bus_start();
        send_byte(8'h60, a);
        chk("rs_ack_id", 32'(a), 32'(ACK));
        send_byte(8'h0A, a);
        chk("rs_ack_sub", 32'(a), 32'(ACK));
        m_addr = 8'h0A;
        rd_txn(8'h61, 1'b1);

        q = {8'h60, 8'h20, 8'h11, 8'h22};
        wr_txn(q);

        for (int n = 0; n < 10; n++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: begin
                    q = {8'h60, 8'($urandom), 8'($urandom)};
                    for (int e = int'($urandom_range(0, 2)); e > 0; e--)
                        q.push_back(8'($urandom));
                    wr_txn(q);
                end
                1: begin
                    q = {8'h60, 8'($urandom)};
                    wr_txn(q);
                end
                2: rd_txn(8'h61, 1'b0);
                default: begin
                    do id = {7'($urandom), 1'b0};
                    while (id[7:1] == 7'h30);
                    q = {id, 8'($urandom), 8'($urandom)};
                    wr_txn(q);
                end
            endcase
        end

        bus_start();
        send_byte(8'h60, a);
        send_byte(8'h33, a);
        put_bit(1'b1);
        put_bit(1'b1);
        put_bit(1'b0);
        put_bit(1'b0);
        chk("pre_rst_addr", 32'(reg_addr), 32'h33);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {26'd0, sda_oe, reg_wr_en, reg_rd_req, busy, 2'b00},
            32'd0);
        chk("mid_rst_regs", {16'd0, reg_addr, reg_wr_data}, 32'd0);
        m_addr = 8'h00;
        #(3*Q);
        sda_m = 1'b1; #Q;
        scl = 1'b1; #Q;
        rst = 1'b0;
        #(4*Q);
        q = {8'h60, 8'h44, 8'h77};
        wr_txn(q);
        rd_txn(8'h61, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
